// File: rtl/core_dbus_bridge.sv
// core_dbus_bridge: turns the RV32I core's single-cycle load/store strobes into
// a registered req/ack bus transaction, stalling the core until completion and
// aborting with a sticky error flag if the slave never acknowledges.
module core_dbus_bridge #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_be,
  input  logic        c_re,
  input  logic        c_we,
  input  logic        ext_halt,
  output logic [31:0] c_rdata,
  output logic        c_halt,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        err
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             req_d, we_d, err_d;
  logic [31:0]      addr_d, wdata_d, rdata_q, rdata_d;
  logic [3:0]       be_d;
  logic             acc;
  logic             unused_addr_bits;

  // Byte offset is carried by the byte enables; the bus only sees word addresses.
  assign unused_addr_bits = ^c_addr[1:0];

  assign acc     = c_re | c_we;
  assign c_rdata = rdata_q;

  // Stall the core until the access reaches DONE; reset masks the access term.
  assign c_halt = ext_halt | (~res & acc & (state != DONE));

  // Next-state and next-register values; everything holds unless a branch changes it.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    req_d   = m_req;
    we_d    = m_we;
    addr_d  = m_addr;
    wdata_d = m_wdata;
    be_d    = m_be;
    rdata_d = rdata_q;
    err_d   = err;
    case (state)
      IDLE: begin
        if (acc) begin
          req_d   = 1'b1;
          we_d    = c_we;
          addr_d  = {c_addr[31:2], 2'b00};
          wdata_d = c_wdata;
          be_d    = c_be;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt + CNT_W'(1);
        if (m_ack) begin
          req_d = 1'b0;
          if (!m_we) rdata_d = m_rdata;
          state_d = DONE;
        end else if (cnt == CNT_LAST) begin
          req_d = 1'b0;
          err_d = 1'b1;
          if (!m_we) rdata_d = ERR_RDATA;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and bus-side registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state   <= IDLE;
      cnt     <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
      rdata_q <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      m_req   <= req_d;
      m_we    <= we_d;
      m_addr  <= addr_d;
      m_wdata <= wdata_d;
      m_be    <= be_d;
      rdata_q <= rdata_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_core_dbus_bridge.sv
// Directed bench for core_dbus_bridge (TIMEOUT=4 so the timeout path is short).
module tb_core_dbus_bridge;

  localparam logic [1:0] S_IDLE = 2'd0;

  logic        clk;
  logic        res;
  logic [31:0] c_addr, c_wdata, c_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  c_be, m_be;
  logic        c_re, c_we, ext_halt, c_halt, m_req, m_we, m_ack, err;

  int checks   = 0;
  int failures = 0;
  int halt_cnt, req_cnt;
  logic [5:0] req_tr, idle_tr, halt_tr;

  core_dbus_bridge #(.TIMEOUT(4), .ERR_RDATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .res(res), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_re(c_re), .c_we(c_we), .ext_halt(ext_halt), .c_rdata(c_rdata),
    .c_halt(c_halt), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    res = 1'b1; c_addr = '0; c_wdata = '0; c_be = '0; c_re = 1'b0; c_we = 1'b0;
    ext_halt = 1'b0; m_ack = 1'b0; m_rdata = '0;
    tick(); tick();

    // Reset state
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(2'(dut.state)), 32'(S_IDLE));
    c_re = 1'b1; #1;
    chk("rst_halt_masked", 32'(c_halt), 32'd0);
    c_re = 1'b0;
    tick();

    // 1: LW zero-wait
    res = 1'b0; c_re = 1'b1; c_addr = 32'h104; c_be = 4'hF; #1;
    chk("t1_halt_c1", 32'(c_halt), 32'd1);
    tick();
    chk("t1_m_req", 32'(m_req), 32'd1);
    chk("t1_m_addr", m_addr, 32'h104);
    chk("t1_m_we", 32'(m_we), 32'd0);
    m_ack = 1'b1; m_rdata = 32'hDEADBEEF; #1;
    chk("t1_halt_c2", 32'(c_halt), 32'd1);
    tick();
    m_ack = 1'b0; #1;
    chk("t1_done_halt", 32'(c_halt), 32'd0);
    chk("t1_rdata", c_rdata, 32'hDEADBEEF);
    chk("t1_req_drop", 32'(m_req), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    tick();
    c_re = 1'b0;

    // 2: SB, 3 wait states; ack lands in the last counted cycle and must win
    c_we = 1'b1; c_addr = 32'h203; c_be = 4'b1000; c_wdata = 32'hAB000000;
    m_rdata = 32'h12345678;
    halt_cnt = 0; req_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      m_ack = (req_cnt == 3) && m_req;
      #1;
      if (c_halt) halt_cnt++;
      if (m_req) req_cnt++;
      if (i == 1) begin
        chk("t2_m_we", 32'(m_we), 32'd1);
        chk("t2_m_addr", m_addr, 32'h200);
        chk("t2_m_be", 32'(m_be), 32'h8);
        chk("t2_m_wdata", m_wdata, 32'hAB000000);
      end
      tick();
    end
    m_ack = 1'b0; c_we = 1'b0;
    chk("t2_req_cycles", 32'(req_cnt), 32'd4);
    chk("t2_halt_cycles", 32'(halt_cnt), 32'd5);
    chk("t2_no_err", 32'(err), 32'd0);
    chk("t2_rdata_kept", c_rdata, 32'hDEADBEEF);

    // 4: back-to-back load 0x10, store 0x14, immediate ack
    c_re = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_be = 4'hF; m_rdata = 32'h11111111;
    for (int i = 0; i < 6; i++) begin
      m_ack = m_req;
      #1;
      req_tr[i]  = m_req;
      idle_tr[i] = (2'(dut.state) == S_IDLE);
      tick();
      if (i == 2) begin
        c_re = 1'b0; c_we = 1'b1; c_addr = 32'h14; c_wdata = 32'h0BADF00D; m_rdata = 32'h22222222;
      end
    end
    m_ack = 1'b0; c_we = 1'b0;
    chk("t4_req_trace", 32'(req_tr), 32'b010010);
    chk("t4_idle_trace", 32'(idle_tr), 32'b001001);
    chk("t4_rdata_load", c_rdata, 32'h11111111);
    chk("t4_m_addr", m_addr, 32'h14);

    // 3: load timeout
    c_re = 1'b1; c_addr = 32'h300; halt_cnt = 0; req_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (c_halt) halt_cnt++;
      if (m_req) req_cnt++;
      tick();
    end
    c_re = 1'b0;
    chk("t3_req_cycles", 32'(req_cnt), 32'd4);
    chk("t3_halt_cycles", 32'(halt_cnt), 32'd5);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_rdata", c_rdata, 32'hFFFFFFFF);
    chk("t3_state", 32'(2'(dut.state)), 32'(S_IDLE));
    tick(); tick();
    chk("t3_err_sticky", 32'(err), 32'd1);

    // 5: reset in BUSY cycle 2
    c_re = 1'b1; c_addr = 32'h40;
    tick(); tick();
    chk("t5_busy", 32'(m_req), 32'd1);
    res = 1'b1; #1;
    chk("t5_halt_in_res", 32'(c_halt), 32'd0);
    tick();
    chk("t5_req", 32'(m_req), 32'd0);
    chk("t5_state", 32'(2'(dut.state)), 32'(S_IDLE));
    chk("t5_rdata", c_rdata, 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    res = 1'b0; c_re = 1'b0; m_ack = 1'b1; m_rdata = 32'h77777777;
    tick();
    m_ack = 1'b0;
    chk("t5_late_ack_req", 32'(m_req), 32'd0);
    chk("t5_late_ack_state", 32'(2'(dut.state)), 32'(S_IDLE));
    chk("t5_late_ack_rdata", c_rdata, 32'd0);

    // 6: ext_halt without access, then ext_halt held through DONE
    ext_halt = 1'b1; #1;
    chk("t6_halt_noacc", 32'(c_halt), 32'd1);
    tick(); tick();
    chk("t6_no_req", 32'(m_req), 32'd0);
    c_re = 1'b1; c_addr = 32'h88; m_rdata = 32'hA5A5A5A5;
    for (int i = 0; i < 6; i++) begin
      m_ack = m_req;
      if (i == 5) ext_halt = 1'b0;
      #1;
      req_tr[i]  = m_req;
      halt_tr[i] = c_halt;
      if (i == 4) chk("t6_reissue_addr", m_addr, 32'h88);
      tick();
      if (i == 2) m_rdata = 32'h5A5A5A5A;
    end
    m_ack = 1'b0; c_re = 1'b0;
    chk("t6_req_trace", 32'(req_tr), 32'b010010);
    chk("t6_halt_trace", 32'(halt_tr), 32'b011111);
    chk("t6_rdata", c_rdata, 32'h5A5A5A5A);
    chk("t6_state", 32'(2'(dut.state)), 32'(S_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
